// File: rtl/div_disp_pkg.sv
// Shared types and constants for the divider result display.
// Holds FSM states, seven-segment codes, digit positions and the double-dabble step.
package div_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Active-low segment codes, segment a on bit 0 through g on bit 6
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] POS_Q_HUN = 3'd7;
  localparam logic [2:0] POS_Q_TEN = 3'd6;
  localparam logic [2:0] POS_Q_UNI = 3'd5;
  localparam logic [2:0] POS_R_TEN = 3'd1;
  localparam logic [2:0] POS_R_UNI = 3'd0;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // One shift-add-3 iteration on {bcd[11:0], bin[7:0]}
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (adj[8+4*i +: 4] >= 4'd5) begin
        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
      end
    end
    return {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low seven-segment code; values 10..15 render blank.
module seg7_decode
  import div_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/div_result_display.sv
// Captures divider quotient/remainder, converts to BCD and scans an 8-digit display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module div_result_display
  import div_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned SHIFT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] quotient,
  input  logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned IterW = $clog2(SHIFT_CYCLES);

  state_e           state_q, state_d;
  logic [19:0]      sr_q, sr_d;
  logic [IterW-1:0] iter_q, iter_d;
  logic [3:0]       rem_q, rem_d;
  logic             done_q, done_d;
  logic [3:0]       q_hun_q, q_hun_d, q_ten_q, q_ten_d, q_uni_q, q_uni_d;
  logic [3:0]       r_ten_q, r_ten_d, r_uni_q, r_uni_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       dig_idx_q, dig_idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       bcd_sel;
  logic [6:0]       seg_code;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    q_hun_d = q_hun_q;
    q_ten_d = q_ten_q;
    q_uni_d = q_uni_q;
    r_ten_d = r_ten_q;
    r_uni_d = r_uni_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          sr_d    = {12'd0, quotient};
          rem_d   = remainder;
          iter_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d   = dabble_step(sr_q);
        iter_d = iter_q + 1'b1;
        if (iter_q == IterW'(SHIFT_CYCLES - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        q_hun_d = sr_q[19:16];
        q_ten_d = sr_q[15:12];
        q_uni_d = sr_q[11:8];
        r_ten_d = (rem_q >= 4'd10) ? 4'd1 : 4'd0;
        r_uni_d = (rem_q >= 4'd10) ? rem_q - 4'd10 : rem_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 1'b1;
    end
  end

  // Select from next-state values so an/seg track the digit registers on the same edge
  always_comb begin
    bcd_sel = BCD_BLANK;
    case (dig_idx_d)
      POS_Q_HUN: bcd_sel = q_hun_d;
      POS_Q_TEN: bcd_sel = q_ten_d;
      POS_Q_UNI: bcd_sel = q_uni_d;
      POS_R_TEN: bcd_sel = r_ten_d;
      POS_R_UNI: bcd_sel = r_uni_d;
      default:   bcd_sel = BCD_BLANK;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (dig_idx_d == POS_Q_HUN && q_hun_d == 4'd0) bcd_sel = BCD_BLANK;
    if (dig_idx_d == POS_Q_TEN && q_hun_d == 4'd0 && q_ten_d == 4'd0) bcd_sel = BCD_BLANK;
    if (dig_idx_d == POS_R_TEN && r_ten_d == 4'd0) bcd_sel = BCD_BLANK;
`endif
  end

  seg7_decode u_seg7_decode (
    .bcd_i(bcd_sel),
    .seg_o(seg_code)
  );

  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    if (bcd_sel != BCD_BLANK) begin
      an_d  = ~(8'd1 << dig_idx_d);
      seg_d = seg_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      iter_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      q_hun_q    <= '0;
      q_ten_q    <= '0;
      q_uni_q    <= '0;
      r_ten_q    <= '0;
      r_uni_q    <= '0;
      scan_cnt_q <= '0;
      dig_idx_q  <= '0;
      an_q       <= 8'hFF;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      iter_q     <= iter_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      q_hun_q    <= q_hun_d;
      q_ten_q    <= q_ten_d;
      q_uni_q    <= q_uni_d;
      r_ten_q    <= r_ten_d;
      r_uni_q    <= r_uni_d;
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_div_result_display.sv
// Self-checking bench for div_result_display with a fast scan rate.
// Honours LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_div_result_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] quotient = 8'd0;
  logic [3:0] remainder = 4'd0;
  logic       busy, done, dp;
  logic [7:0] an;
  logic [6:0] seg;

  always #5 clk = ~clk;

  div_result_display #(
    .SCAN_DIV    (SD),
    .SHIFT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: transaction phase, captured operands, decimal digits on screen
  int         k;
  int         p;
  logic [7:0] cq;
  logic [3:0] cr;
  logic       done_e;
  int         m_hun, m_ten, m_uni, m_rt, m_ru;
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; p <= 0; done_e <= 1'b0; cq <= '0; cr <= '0;
      m_hun <= 0; m_ten <= 0; m_uni <= 0; m_rt <= 0; m_ru <= 0;
    end else begin
      k      <= k + 1;
      done_e <= 1'b0;
      if (p == 0) begin
        if (load) begin
          p  <= 1;
          cq <= quotient;
          cr <= remainder;
        end
      end else if (p < 9) begin
        p <= p + 1;
      end else begin
        p      <= 0;
        done_e <= 1'b1;
        m_hun  <= int'(cq) / 100;
        m_ten  <= (int'(cq) / 10) % 10;
        m_uni  <= int'(cq) % 10;
        m_rt   <= int'(cr) / 10;
        m_ru   <= int'(cr) % 10;
      end
    end
  end

  function automatic logic [14:0] exp_view(input int slot);
    int d;
    logic [7:0] a;
    case (slot)
      7: d = m_hun;
      6: d = m_ten;
      5: d = m_uni;
      1: d = m_rt;
      0: d = m_ru;
      default: d = -1;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 7 && m_hun == 0) d = -1;
    if (slot == 6 && m_hun == 0 && m_ten == 0) d = -1;
    if (slot == 1 && m_rt == 0) d = -1;
`endif
    if (d < 0) return {8'hFF, 7'h7F};
    a = ~(8'd1 << slot);
    return {a, segtab[d]};
  endfunction

  logic [14:0] ev;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", seg, 7'h7F);
    end else begin
      ev = (k == 0) ? {8'hFF, 7'h7F} : exp_view((k / SD) % 8);
      chk("busy", busy, (p != 0));
      chk("done", done, done_e);
      chk("dp", dp, 1);
      chk("an", an, ev[14:7]);
      chk("seg", seg, ev[6:0]);
    end
  end

  // Wait for a given digit slot, then compare against literal expectations
  task automatic check_slot(input string name, input int slot, input logic [7:0] ea,
                            input logic [6:0] es);
    bit found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (rst_n && k > 0 && (k / SD) % 8 == slot) found = 1;
    end
    chk({name, "_reached"}, found, 1);
    chk({name, "_an"}, an, ea);
    chk({name, "_seg"}, seg, es);
  endtask

  task automatic wait_done(input string name);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    chk({name, "_done_seen"}, found, 1);
  endtask

  task automatic start(input logic [7:0] q, input logic [3:0] r);
    @(negedge clk);
    quotient  = q;
    remainder = r;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  int nb, nd;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: zeros on screen, no done
    nd = 0;
    for (int i = 0; i < 4 * SD; i++) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("idle_no_done", nd, 0);
    check_slot("t1_s7", 7, Lzb ? 8'hFF : 8'h7F, Lzb ? 7'h7F : 7'h40);
    check_slot("t1_s0", 0, 8'hFE, 7'h40);
    check_slot("t1_s3", 3, 8'hFF, 7'h7F);

    // 255 r 15: busy for 9 samples then a single done
    @(negedge clk);
    quotient = 8'd255; remainder = 4'd15; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      nb += int'(busy);
      nd += int'(done);
      @(negedge clk);
    end
    chk("t2_busy_cycles", nb, 9);
    chk("t2_done_pulses", nd, 1);
    check_slot("t2_s7", 7, 8'h7F, 7'h24);
    check_slot("t2_s6", 6, 8'hBF, 7'h12);
    check_slot("t2_s5", 5, 8'hDF, 7'h12);
    check_slot("t2_s1", 1, 8'hFD, 7'h79);
    check_slot("t2_s0", 0, 8'hFE, 7'h12);

    // 42 r 9
    start(8'd42, 4'd9);
    wait_done("t3");
    check_slot("t3_s7", 7, Lzb ? 8'hFF : 8'h7F, Lzb ? 7'h7F : 7'h40);
    check_slot("t3_s6", 6, 8'hBF, 7'h19);
    check_slot("t3_s5", 5, 8'hDF, 7'h24);
    check_slot("t3_s1", 1, Lzb ? 8'hFF : 8'hFD, Lzb ? 7'h7F : 7'h40);
    check_slot("t3_s0", 0, 8'hFE, 7'h10);

    // A load during conversion of 100 is dropped
    start(8'd100, 4'd3);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) begin
        quotient = 8'd7; remainder = 4'd1; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      nd += int'(done);
      @(negedge clk);
    end
    chk("t4_single_done", nd, 1);
    check_slot("t4_s7", 7, 8'h7F, 7'h79);
    check_slot("t4_s6", 6, 8'hBF, 7'h40);
    check_slot("t4_s5", 5, 8'hDF, 7'h40);
    start(8'd7, 4'd1);
    wait_done("t4b");
    check_slot("t4b_s5", 5, 8'hDF, 7'h78);
    check_slot("t4b_s0", 0, 8'hFE, 7'h79);

    // load held high: back-to-back conversions
    @(negedge clk);
    quotient = 8'd13; remainder = 4'd12; load = 1'b1;
    @(negedge clk);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      nd += int'(done);
      if (i == 10) chk("t_hold_restart_busy", busy, 1);
      @(negedge clk);
    end
    load = 1'b0;
    chk("t_hold_two_dones", nd, 2);
    wait_done("t_hold_drain");
    check_slot("t_hold_s6", 6, 8'hBF, 7'h79);
    check_slot("t_hold_s1", 1, 8'hFD, 7'h79);
    check_slot("t_hold_s0", 0, 8'hFE, 7'h24);

    // Reset in the middle of a conversion of 200
    start(8'd200, 4'd6);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_an", an, 8'hFF);
    chk("t5_seg", seg, 7'h7F);
    chk("t5_dp", dp, 1);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("t5_no_done", nd, 0);
    check_slot("t5_s7", 7, Lzb ? 8'hFF : 8'h7F, Lzb ? 7'h7F : 7'h40);
    check_slot("t5_s5", 5, 8'hDF, 7'h40);
    check_slot("t5_s0", 0, 8'hFE, 7'h40);

    // 0 r 0
    start(8'd0, 4'd0);
    wait_done("t6");
    check_slot("t6_s7", 7, Lzb ? 8'hFF : 8'h7F, Lzb ? 7'h7F : 7'h40);
    check_slot("t6_s6", 6, Lzb ? 8'hFF : 8'hBF, Lzb ? 7'h7F : 7'h40);
    check_slot("t6_s5", 5, 8'hDF, 7'h40);
    check_slot("t6_s1", 1, Lzb ? 8'hFF : 8'hFD, Lzb ? 7'h7F : 7'h40);
    check_slot("t6_s0", 0, 8'hFE, 7'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
